// File: rtl/scan_counter_display_pkg.sv
// Shared constants and segment encoding for the scanned counter display.
// Latency: none (types/functions only).
// Backpressure: none.
package scan_counter_display_pkg;

    localparam int MAX_DIGITS = 8;

    localparam logic [7:0] SEG_BLANK = 8'h00;
    localparam logic [7:0] COM_OFF   = 8'hFF;

    localparam logic [7:0] SEG_0 = 8'hFC;
    localparam logic [7:0] SEG_1 = 8'h60;
    localparam logic [7:0] SEG_2 = 8'hDA;
    localparam logic [7:0] SEG_3 = 8'hF2;
    localparam logic [7:0] SEG_4 = 8'h66;
    localparam logic [7:0] SEG_5 = 8'hB6;
    localparam logic [7:0] SEG_6 = 8'hBE;
    localparam logic [7:0] SEG_7 = 8'hE0;
    localparam logic [7:0] SEG_8 = 8'hFE;
    localparam logic [7:0] SEG_9 = 8'hF6;

    typedef logic [3:0] bcd_t;

    // Segment pattern {a,b,c,d,e,f,g,dp=0}; non-decimal codes show nothing.
    function automatic logic [7:0] seg_encode(input bcd_t d);
        case (d)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/scan_counter_display_if.sv
// Control inputs and display/carry outputs of the scanned counter.
// Latency: n/a (wiring only).
// Backpressure: none; all signals are level or single-cycle pulses.
interface scan_counter_display_if;
    logic       run;
    logic       clear;
    logic       blank_lz;
    logic       carry_out;
    logic [7:0] seg_com;
    logic [7:0] seg_data;

    modport master (output run, output clear, output blank_lz,
                    input carry_out, input seg_com, input seg_data);
    modport slave  (input run, input clear, input blank_lz,
                    output carry_out, output seg_com, output seg_data);
endinterface

// File: rtl/bcd_digit_cell.sv
// One counter digit wrapping at max_val; passes an increment up when it wraps.
// Latency: digit updates on the edge after inc_in; inc_out is combinational.
// Backpressure: none.
module bcd_digit_cell
    import scan_counter_display_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic inc_in,
    input  bcd_t max_val,
    output bcd_t digit,
    output logic inc_out
);

    logic at_max;

    // >= keeps the digit legal even if max_val ever sat below the held value.
    assign at_max  = (digit >= max_val);
    assign inc_out = inc_in && at_max;

    always_ff @(posedge clk) begin
        if (!rst) begin
            digit <= '0;
        end else if (clear) begin
            digit <= '0;
        end else if (inc_in) begin
            digit <= at_max ? '0 : digit + 4'd1;
        end
    end

endmodule

// File: rtl/scan_counter_display.sv
// N-digit cascaded counter with prescaled count rate and multiplexed 7-seg drive.
// Latency: seg_com/seg_data/carry_out are registered, one cycle behind counter/scan state.
// Backpressure: none; run gates counting, clear overrides the count tick.
module scan_counter_display
    import scan_counter_display_pkg::*;
#(
    parameter int NUM_DIGITS = 6,
    parameter int CNT_DIV    = 1000,
    parameter int SCAN_DIV   = 100,
    parameter int TIME_MODE  = 1
)
(
    input  logic                  clk,
    input  logic                  rst,
    scan_counter_display_if.slave bus
);

    localparam int CW = (CNT_DIV  > 1) ? $clog2(CNT_DIV)  : 1;
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(CNT_DIV - 1);
    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
    localparam logic [2:0]    IDX_LAST  = 3'(NUM_DIGITS - 1);

    logic [CW-1:0]         cnt_pre;
    logic [SW-1:0]         scan_pre;
    logic [2:0]            scan_idx;
    logic                  tick;
    logic [NUM_DIGITS:0]   chain;
    bcd_t                  digits [MAX_DIGITS];
    logic [MAX_DIGITS-1:0] zero_from;
    bcd_t                  cur_digit;
    logic                  blank;
    logic                  dp;

    assign tick     = bus.run && (cnt_pre == CNT_LAST);
    assign chain[0] = tick;

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_pre <= '0;
        end else if (bus.clear) begin
            cnt_pre <= '0;
        end else if (bus.run) begin
            cnt_pre <= tick ? '0 : cnt_pre + CW'(1);
        end
    end

    // Scan keeps running through run=0 and clear so the display never freezes.
    always_ff @(posedge clk) begin
        if (!rst) begin
            scan_pre <= '0;
            scan_idx <= '0;
        end else if (scan_pre == SCAN_LAST) begin
            scan_pre <= '0;
            scan_idx <= (scan_idx == IDX_LAST) ? 3'd0 : scan_idx + 3'd1;
        end else begin
            scan_pre <= scan_pre + SW'(1);
        end
    end

    for (genvar i = 0; i < MAX_DIGITS; i++) begin : g_digit
        if (i < NUM_DIGITS) begin : g_cell
            localparam bcd_t MAXV = (TIME_MODE != 0 && (i % 2) == 1) ? 4'd5 : 4'd9;
            bcd_digit_cell u_cell (
                .clk     (clk),
                .rst     (rst),
                .clear   (bus.clear),
                .inc_in  (chain[i]),
                .max_val (MAXV),
                .digit   (digits[i]),
                .inc_out (chain[i+1])
            );
        end else begin : g_unused
            assign digits[i] = '0;
        end
    end

    always_comb begin
        logic all_zero;
        zero_from = '0;
        all_zero  = 1'b1;
        for (int i = MAX_DIGITS - 1; i >= 0; i--) begin
            all_zero     = all_zero && (digits[i] == 4'd0);
            zero_from[i] = all_zero;
        end
        cur_digit = digits[scan_idx];
        blank     = bus.blank_lz && (scan_idx != 3'd0) && zero_from[scan_idx];
        dp        = (TIME_MODE != 0) && !scan_idx[0] && (scan_idx >= 3'd2);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            bus.seg_com   <= COM_OFF;
            bus.seg_data  <= SEG_BLANK;
            bus.carry_out <= 1'b0;
        end else begin
            bus.seg_com   <= COM_OFF & ~(8'h80 >> scan_idx);
            bus.seg_data  <= blank ? SEG_BLANK : (seg_encode(cur_digit) | {7'd0, dp});
            bus.carry_out <= !bus.clear && chain[NUM_DIGITS];
        end
    end

endmodule
